invsqrt_arbiter: RTL and testbench
==================================

# invsqrt_arbiter

Round-robin arbiter and tag tracker that shares one pipelined `InvertSQRoot` core between `NUM_REQ` independent requesters. Each cycle it issues at most one accepted 32-bit float operand into the core and records the requester ID in a tag pipeline aligned with the core latency. Each result is routed back to the requester that issued it. It sits between the per-channel operand sources and the single inverse-square-root datapath instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CORE_LAT`, 4: core latency in clocks from `core_DataIn` sampled to the matching `core_DataOut`/`core_DataValid`, ≥1.
- `IDW`, $clog2(NUM_REQ): tag width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  global enable; low freezes the arbiter, issue stage, tag pipe and core.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_data`  in  32*NUM_REQ  operands, requester i in bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot grant; the operand is accepted when valid&ready.
- `rsp_valid`  out  NUM_REQ  one-hot result strobe, one cycle.
- `rsp_data`  out  32  result word, valid for the requester flagged in `rsp_valid`.
- `core_ce`  out  1  to core `ce`.
- `core_DataIn`  out  32  to core `DataIn`.
- `core_DataOut`  in  32  from core.
- `core_DataValid`  in  1  from core.
- `err`  out  1  sticky tag/core mismatch flag.

## Operation
- Arbiter:
  - Combinational round-robin over `req_valid`, starting at `rr_ptr`.
  - `req_ready[i]` = 1 only for the granted i, and only when `ce`=1 and `rst`=0.
  - Never more than one bit set. A requester with valid low never gets ready.
- Pointer update: on accept, `rr_ptr` ← granted index+1, mod NUM_REQ. With no accept, `rr_ptr` holds.
- Issue stage (registered):
  - On accept, `core_DataIn` ← selected operand and `iss_vld` ← 1, `iss_id` ← index.
  - With no accept and `ce`=1, `iss_vld` ← 0 and `core_DataIn` holds its last value.
- Core enable: `core_ce` = `ce` (combinational passthrough).
- Tag pipe:
  - Shift register of CORE_LAT entries of {vld, id}, fed from {`iss_vld`, `iss_id`}.
  - Advances only when `ce`=1, in lockstep with the core.
- Response stage (registered): when `ce`=1 and the tag pipe output vld=1:
  - `rsp_valid[id]` ← 1 and `rsp_data` ← `core_DataOut`.
  - Otherwise `rsp_valid` ← 0 and `rsp_data` holds.
- Responses have no backpressure. Requesters must accept `rsp_valid` in the same cycle.
- Data is not modified. Special inputs (zero, negative, NaN) pass to the core unchanged.
- Reset values: `rr_ptr`=0, `iss_vld`=0, `core_DataIn`=0, all tag vld=0, `rsp_valid`=0, `rsp_data`=0, `err`=0.
- Reset mid-operation clears all in-flight tags. Results already in the core are dropped and never produce `rsp_valid`.

## Timing
- Request accepted at edge t; `core_DataIn` is valid after edge t.
- Result appears on `rsp_valid`/`rsp_data` after edge t+CORE_LAT+1. Total latency is CORE_LAT+2 cycles, counting only cycles with `ce`=1.
- Throughput: one operand per enabled cycle across all requesters.
- With all requesters valid, grants rotate 0,1,2,3,0,…. Each requester gets 1/NUM_REQ of the throughput.
- A requester held valid without a grant keeps `req_data` stable until it sees ready.
- `ce` low for k cycles stretches latency by k. No tag or result is lost or duplicated.
- `ce` low the same cycle as a valid request means no accept; `rr_ptr` is unchanged.

## Configuration
- `INVSQRT_ARB_ERRCHK_EN` defined:
  - Each enabled cycle, compares the tag-pipe output vld against `core_DataValid`.
  - Tag vld=1 with `core_DataValid`=0 sets `err`, which stays sticky until `rst`.
  - Tag vld=0 with `core_DataValid`=1 is legal (pipeline fill of idle slots) and does not set `err`.
- Not defined: no check logic; `err` is tied 0.

## Test plan
- Single request: requester 2 sends 0x40800000 (4.0). Exactly one `rsp_valid`=4'b0100 arrives CORE_LAT+2 cycles later with `rsp_data` within ±2 LSB of 0x3F000000. No other strobes.
- All four requesters valid continuously with distinct operands (1.0, 4.0, 16.0, 0.25):
  - Grants follow 0,1,2,3 repeating.
  - Responses return in issue order: 0x3F800000, 0x3F000000, 0x3E800000, 0x40000000, each ±2 LSB, to the matching requester.
- Stall: drop `ce` for 3 cycles with 3 operations in flight. All 3 responses arrive exactly 3 cycles late, in order, with correct IDs.
- Reset mid-flight: assert `rst` with CORE_LAT operations outstanding. All outputs return to reset values immediately, and no `rsp_valid` follows for the dropped operations.
- Error check (macro defined): a stub core that holds `core_DataValid`=0 while a tag is valid sets `err`=1 at that edge, and `err` stays 1 until `rst`. With the macro undefined, `err` remains 0.
- Random soak: 1000 random operands over random requesters and random `ce` gaps, checked against a golden model. Every result is within ±2 LSB of the golden value, and the count of responses per requester equals the count of accepts.

Source files
------------

// File: rtl/invsqrt_arbiter.sv
// Round-robin front end that shares one pipelined inverse-sqrt core between NUM_REQ requesters.
// Define INVSQRT_ARB_ERRCHK_EN to build the sticky tag/core valid mismatch check on err.
module invsqrt_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int CORE_LAT = 4,
   parameter int IDW      = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_data,
   output logic                  core_ce,
   output logic [31:0]           core_DataIn,
   input  logic [31:0]           core_DataOut,
   input  logic                  core_DataValid,
   output logic                  err
);

   logic [IDW-1:0]                rr_ptr;
   logic [NUM_REQ-1:0]            hi_mask;
   logic [NUM_REQ-1:0]            masked;
   logic [NUM_REQ-1:0]            pick_src;
   logic [NUM_REQ-1:0]            grant;
   logic [IDW-1:0]                grant_idx;
   logic [31:0]                   grant_data;
   logic                          accept;
   logic                          iss_vld;
   logic [IDW-1:0]                iss_id;
   logic [CORE_LAT-1:0]           tag_vld;
   logic [CORE_LAT-1:0][IDW-1:0]  tag_id;
   logic                          tag_vld_out;
   logic [IDW-1:0]                tag_id_out;
   logic [NUM_REQ-1:0]            rsp_hit;
   logic [IDW-1:0][NUM_REQ-1:0]   idx_bits;
   logic [31:0][NUM_REQ-1:0]      data_bits;

   // Per-requester terms; the one-hot grant is turned into an index and a data mux by OR-reduction.
   genvar gi, bi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign hi_mask[gi] = (IDW'(gi) >= rr_ptr);
         assign rsp_hit[gi] = (tag_id_out == IDW'(gi));
         for (bi = 0; bi < IDW; bi++) begin : g_idx
            assign idx_bits[bi][gi] = grant[gi] & (((gi >> bi) & 1) != 0);
         end
         for (bi = 0; bi < 32; bi++) begin : g_dat
            assign data_bits[bi][gi] = grant[gi] & req_data[32*gi + bi];
         end
      end
      for (bi = 0; bi < IDW; bi++) begin : g_idx_or
         assign grant_idx[bi] = |idx_bits[bi];
      end
      for (bi = 0; bi < 32; bi++) begin : g_dat_or
         assign grant_data[bi] = |data_bits[bi];
      end
   endgenerate

   // Requesters at or above the pointer win first; otherwise wrap to the lowest valid one.
   assign masked    = req_valid & hi_mask;
   assign pick_src  = (|masked) ? masked : req_valid;
   assign grant     = pick_src & (~pick_src + NUM_REQ'(1));
   assign req_ready = (ce && !rst) ? grant : '0;
   assign accept    = |req_ready;
   assign core_ce   = ce;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= '0;
         iss_vld     <= 1'b0;
         iss_id      <= '0;
         core_DataIn <= '0;
      end else if (ce) begin
         iss_vld <= accept;
         if (accept) begin
            rr_ptr      <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
            iss_id      <= grant_idx;
            core_DataIn <= grant_data;
         end
      end
   end

   // Tag pipe advances in lockstep with the core so its output lines up with core_DataOut.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else if (ce) begin
         tag_vld <= CORE_LAT'({tag_vld, iss_vld});
         tag_id  <= (CORE_LAT*IDW)'({tag_id, iss_id});
      end
   end

   assign tag_vld_out = tag_vld[CORE_LAT-1];
   assign tag_id_out  = tag_id[CORE_LAT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else if (ce && tag_vld_out) begin
         rsp_valid <= rsp_hit;
         rsp_data  <= core_DataOut;
      end else begin
         rsp_valid <= '0;
      end
   end

`ifdef INVSQRT_ARB_ERRCHK_EN
   // A tagged slot must carry a core result; an untagged slot may (idle fill) or may not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (ce && tag_vld_out && !core_DataValid) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_core_valid;
   assign unused_core_valid = core_DataValid;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// Directed and soak bench for invsqrt_arbiter driving a stub core with known results.
`timescale 1ns/1ps
module tb_invsqrt_arbiter;
   localparam int NUM_REQ  = 4;
   localparam int CORE_LAT = 4;
   localparam int LAT      = CORE_LAT + 1;  // accept edge to response edge
`ifdef INVSQRT_ARB_ERRCHK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  ce;
   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_data;
   logic                  core_ce;
   logic [31:0]           core_DataIn;
   logic [31:0]           core_DataOut;
   logic                  core_DataValid;
   logic                  err;
   logic                  kill;

   invsqrt_arbiter #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT)) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .core_ce(core_ce), .core_DataIn(core_DataIn),
      .core_DataOut(core_DataOut), .core_DataValid(core_DataValid),
      .err(err)
   );

   always #5 clk = ~clk;

   // Stub core: exact 1/sqrt for the four test operands, a fixed XOR for anything else.
   function automatic logic [31:0] core_f(input logic [31:0] x);
      case (x)
         32'h3F800000: return 32'h3F800000;
         32'h40800000: return 32'h3F000000;
         32'h41800000: return 32'h3E800000;
         32'h3E800000: return 32'h40000000;
         default:      return x ^ 32'hFFFF0000;
      endcase
   endfunction

   logic [31:0]         cpipe [CORE_LAT];
   logic [CORE_LAT-1:0] cvld;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cvld <= '0;
      end else if (core_ce) begin
         cpipe[0] <= core_f(core_DataIn);
         for (int k = 1; k < CORE_LAT; k++) cpipe[k] <= cpipe[k-1];
         cvld <= {cvld[CORE_LAT-2:0], 1'b1};
      end
   end
   assign core_DataOut   = cpipe[CORE_LAT-1];
   assign core_DataValid = cvld[CORE_LAT-1] & ~kill;

   typedef struct {
      int                 cyc;
      logic [NUM_REQ-1:0] vec;
      logic [31:0]        data;
   } rsp_t;
   rsp_t rsp_q[$];
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rsp_valid != '0) rsp_q.push_back('{cyc, rsp_valid, rsp_data});

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic set_data(input int r, input logic [31:0] d);
      req_data[32*r +: 32] = d;
   endtask

   logic [31:0] exp_q [NUM_REQ][$];
   int          acc_cnt [NUM_REQ];
   int          rsp_cnt [NUM_REQ];

   task automatic soak_rsp();
      if (rsp_valid != '0) begin
         chk("soak_onehot", 32'($onehot(rsp_valid)), 1);
         for (int r = 0; r < NUM_REQ; r++) begin
            if (rsp_valid[r]) begin
               rsp_cnt[r]++;
               chk($sformatf("soak_pending%0d", r), 32'(exp_q[r].size() != 0), 1);
               if (exp_q[r].size() != 0) chk($sformatf("soak_data%0d", r), rsp_data, exp_q[r].pop_front());
            end
         end
      end
   endtask

   initial begin
      int          e;
      int          sent;
      logic [31:0] ops [4];
      logic [31:0] gold [4];
      logic [31:0] stall_gold [3];
      logic [NUM_REQ-1:0] one;
      logic [NUM_REQ-1:0] pend;
      logic [31:0] pdata [NUM_REQ];
      rsp_t        r;

      one = 4'b0001;
      rst = 1'b1; ce = 1'b1; kill = 1'b0; req_valid = '0; req_data = '0;

      // Reset state, with every requester asking
      tick();
      req_valid = 4'hF;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_core_in", core_DataIn, 0);
      chk("rst_err", err, 0);
      chk("rst_core_ce", core_ce, 1);
      req_valid = '0;
      tick();
      rst = 1'b0;
      tick();

      // Single request from requester 2: 4.0 -> 0.5
      rsp_q.delete();
      set_data(2, 32'h40800000);
      req_valid = 4'b0100;
      #1;
      chk("single_ready", req_ready, 4'b0100);
      e = cyc + 1;
      tick();
      req_valid = '0;
      chk("single_issue", core_DataIn, 32'h40800000);
      ticks(10);
      chk("single_count", rsp_q.size(), 1);
      if (rsp_q.size() == 1) begin
         r = rsp_q[0];
         chk("single_time", r.cyc, e + LAT);
         chk("single_vec", r.vec, 4'b0100);
         chk("single_data", r.data, 32'h3F000000);
      end

      // All four valid: grants rotate 0,1,2,3 and results return in issue order
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp_q.delete();
      ops  = '{32'h3F800000, 32'h40800000, 32'h41800000, 32'h3E800000};
      gold = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h40000000};
      for (int k = 0; k < 4; k++) set_data(k, ops[k]);
      req_valid = 4'hF;
      e = cyc + 1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("rr_grant%0d", k), req_ready, one << (k % 4));
         tick();
      end
      req_valid = '0;
      ticks(10);
      chk("rr_count", rsp_q.size(), 8);
      for (int k = 0; k < 8 && k < rsp_q.size(); k++) begin
         r = rsp_q[k];
         chk($sformatf("rr_time%0d", k), r.cyc, e + LAT + k);
         chk($sformatf("rr_vec%0d", k), r.vec, one << (k % 4));
         chk($sformatf("rr_data%0d", k), r.data, gold[k % 4]);
      end

      // Three in flight, ce low for three cycles
      rsp_q.delete();
      set_data(0, 32'h11111111);
      set_data(1, 32'h22222222);
      set_data(2, 32'h33333333);
      set_data(3, 32'h44444444);
      stall_gold = '{32'hEEEE1111, 32'hDDDD2222, 32'hCCCC3333};
      req_valid = 4'b0111;
      e = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall_grant%0d", k), req_ready, one << k);
         tick();
      end
      req_valid = 4'hF;
      ce = 1'b0;
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_core_ce", core_ce, 0);
      ticks(3);
      ce = 1'b1;
      req_valid = '0;
      ticks(10);
      chk("stall_count", rsp_q.size(), 3);
      for (int k = 0; k < 3 && k < rsp_q.size(); k++) begin
         r = rsp_q[k];
         chk($sformatf("stall_time%0d", k), r.cyc, e + LAT + 3 + k);
         chk($sformatf("stall_vec%0d", k), r.vec, one << k);
         chk($sformatf("stall_data%0d", k), r.data, stall_gold[k]);
      end

      // Pointer held through the stall, then reset with CORE_LAT operations outstanding
      rsp_q.delete();
      req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("mid_grant%0d", k), req_ready, one << ((k + 3) % 4));
         tick();
      end
      #1;
      rst = 1'b1;
      #1;
      chk("mid_ready", req_ready, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_rsp_data", rsp_data, 0);
      chk("mid_core_in", core_DataIn, 0);
      chk("mid_err", err, 0);
      req_valid = '0;
      tick();
      rst = 1'b0;
      ticks(12);
      chk("mid_dropped", rsp_q.size(), 0);

      // Core withholds DataValid while a tag reaches the end of the pipe
      rsp_q.delete();
      kill = 1'b1;
      set_data(0, 32'h3F800000);
      req_valid = 4'b0001;
      #1;
      chk("err_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      ticks(4);
      chk("err_before", err, 0);
      tick();
      chk("err_set", err, EXP_ERR);
      kill = 1'b0;
      ticks(3);
      chk("err_sticky", err, EXP_ERR);
      chk("err_rsp_count", rsp_q.size(), 1);
      rst = 1'b1;
      #1;
      chk("err_cleared", err, 0);
      tick();
      rst = 1'b0;
      tick();

      // Random soak against the stub-core model
      sent = 0;
      pend = '0;
      for (int q = 0; q < NUM_REQ; q++) begin
         acc_cnt[q] = 0;
         rsp_cnt[q] = 0;
         exp_q[q].delete();
         pdata[q] = '0;
      end
      for (int n = 0; n < 20000 && sent < 1000; n++) begin
         for (int q = 0; q < NUM_REQ; q++) begin
            if (!pend[q] && sent + int'($countones(pend)) < 1000 && $urandom_range(0, 2) == 0) begin
               pend[q]  = 1'b1;
               pdata[q] = $urandom;
            end
            set_data(q, pdata[q]);
         end
         req_valid = pend;
         ce = ($urandom_range(0, 4) != 0);
         #1;
         for (int q = 0; q < NUM_REQ; q++) begin
            if (req_valid[q] && req_ready[q]) begin
               exp_q[q].push_back(core_f(pdata[q]));
               pend[q] = 1'b0;
               acc_cnt[q]++;
               sent++;
            end
         end
         tick();
         soak_rsp();
      end
      req_valid = '0;
      ce = 1'b1;
      for (int n = 0; n < 3 * LAT; n++) begin
         tick();
         soak_rsp();
      end
      chk("soak_sent", sent, 1000);
      for (int q = 0; q < NUM_REQ; q++) begin
         chk($sformatf("soak_count%0d", q), rsp_cnt[q], acc_cnt[q]);
      end
      chk("soak_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
